// File: rtl/riscv_if_pfq.sv
// Instruction prefetch queue: issues aligned fetches, tracks them in order and
// presents the returned parcels (with PC and fault flags) to the fetch stage.
module riscv_if_pfq #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32,
  parameter int DEPTH       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [XLEN-1:0]           if_nxt_pc,
  input  logic                      if_stall,
  input  logic                      if_flush,
  output logic                      if_stall_nxt_pc,
  output logic [PARCEL_SIZE-1:0]    if_parcel,
  output logic [XLEN-1:0]           if_parcel_pc,
  output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
  output logic                      if_parcel_misaligned,
  output logic                      if_parcel_page_fault,
  output logic                      mem_req,
  output logic [XLEN-1:0]           mem_adr,
  input  logic                      mem_ack,
  input  logic                      mem_rvalid,
  input  logic [PARCEL_SIZE-1:0]    mem_d,
  input  logic                      mem_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;
  localparam int NV = PARCEL_SIZE / 16;

  logic [PARCEL_SIZE-1:0] dq_data [DEPTH];
  logic [XLEN-1:0]        dq_pc   [DEPTH];
  logic [DEPTH-1:0]       dq_mis;
  logic [DEPTH-1:0]       dq_pf;
  logic [XLEN-1:0]        tq_pc   [DEPTH];
  logic [DEPTH-1:0]       tq_mis;

  logic [PW-1:0] dq_rd, dq_wr, tq_rd, tq_wr;
  logic [CW-1:0] occupancy, outstanding, discard;

  logic          space, accept, counted, pop, dq_valid;
  logic [SW-1:0] total;

  // Slots already in flight to be discarded still hold memory-side capacity.
  assign total    = SW'(occupancy) + SW'(outstanding) + SW'(discard);
  assign space    = total < SW'(DEPTH);

  assign mem_req         = ~rst & ~if_flush & space;
  assign accept          = mem_req & mem_ack;
  assign if_stall_nxt_pc = ~accept;
  assign mem_adr         = {if_nxt_pc[XLEN-1:2], 2'b00};

  assign counted  = mem_rvalid & (discard == '0) & ~if_flush;
  assign dq_valid = (occupancy != '0);
  assign pop      = dq_valid & ~if_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq_rd       <= '0;
      dq_wr       <= '0;
      tq_rd       <= '0;
      tq_wr       <= '0;
      occupancy   <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (if_flush) begin
      dq_rd       <= '0;
      dq_wr       <= '0;
      tq_rd       <= '0;
      tq_wr       <= '0;
      occupancy   <= '0;
      outstanding <= '0;
      // Every request still in flight becomes a discard, less any response
      // that lands (and is dropped) in this very cycle.
      discard     <= discard + outstanding - CW'(mem_rvalid);
    end else begin
      if (accept)
        tq_wr <= tq_wr + 1'b1;
      if (counted) begin
        tq_rd <= tq_rd + 1'b1;
        dq_wr <= dq_wr + 1'b1;
      end
      if (pop)
        dq_rd <= dq_rd + 1'b1;
      occupancy   <= occupancy + CW'(counted) - CW'(pop);
      outstanding <= outstanding + CW'(accept) - CW'(counted);
      if (mem_rvalid && (discard != '0))
        discard <= discard - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      tq_pc[tq_wr]  <= if_nxt_pc;
      tq_mis[tq_wr] <= |if_nxt_pc[1:0];
    end
    if (counted) begin
      dq_data[dq_wr] <= mem_d;
      dq_pc[dq_wr]   <= tq_pc[tq_rd];
      dq_mis[dq_wr]  <= tq_mis[tq_rd];
      dq_pf[dq_wr]   <= mem_err;
    end
  end

  assign if_parcel            = dq_valid ? dq_data[dq_rd] : '0;
  assign if_parcel_pc         = dq_valid ? dq_pc[dq_rd]   : '0;
  assign if_parcel_misaligned = dq_valid & dq_mis[dq_rd];
  assign if_parcel_page_fault = dq_valid & dq_pf[dq_rd];
  assign if_parcel_valid      = dq_valid ? {NV{1'b1}} : '0;

  a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
    mem_rvalid |-> ((outstanding != '0) || (discard != '0)));

endmodule

// File: tb/tb_riscv_if_pfq.sv
// Bench for riscv_if_pfq: directed scenarios plus randomized traffic against a
// queue-based model of requests in flight and parcels waiting for the fetch stage.
module tb_riscv_if_pfq;

  localparam int XLEN  = 32;
  localparam int PS    = 32;
  localparam int DEPTH = 4;
  localparam int NV    = PS / 16;
  localparam int VW    = 2 + XLEN + NV + PS + XLEN + 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [XLEN-1:0] if_nxt_pc;
  logic            if_stall, if_flush, if_stall_nxt_pc;
  logic [PS-1:0]   if_parcel;
  logic [XLEN-1:0] if_parcel_pc;
  logic [NV-1:0]   if_parcel_valid;
  logic            if_parcel_misaligned, if_parcel_page_fault;
  logic            mem_req;
  logic [XLEN-1:0] mem_adr;
  logic            mem_ack, mem_rvalid;
  logic [PS-1:0]   mem_d;
  logic            mem_err;

  riscv_if_pfq #(.XLEN(XLEN), .PARCEL_SIZE(PS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .if_nxt_pc(if_nxt_pc), .if_stall(if_stall), .if_flush(if_flush),
    .if_stall_nxt_pc(if_stall_nxt_pc), .if_parcel(if_parcel), .if_parcel_pc(if_parcel_pc),
    .if_parcel_valid(if_parcel_valid), .if_parcel_misaligned(if_parcel_misaligned),
    .if_parcel_page_fault(if_parcel_page_fault), .mem_req(mem_req), .mem_adr(mem_adr),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_d(mem_d), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [PS-1:0]   data;
    logic            err;
    logic            live;
    int              cyc;
  } req_t;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [PS-1:0]   data;
    logic            err;
  } parcel_t;

  req_t            inflight[$];
  parcel_t         parcel_q[$];
  logic [XLEN-1:0] pc_tab[$];
  logic            stall_d, flush_d, ack_d, rv_en, err_rand;
  logic [XLEN-1:0] pc_d, err_pc;
  int              cyc, n_vec, n_err;

  logic [VW-1:0] act_vec;
  assign act_vec = {mem_req, if_stall_nxt_pc, mem_adr, if_parcel_valid, if_parcel,
                    if_parcel_pc, if_parcel_misaligned, if_parcel_page_fault};

  // Every slot is either a parcel waiting in the queue or a request in flight.
  function automatic logic model_req();
    return !rst && !flush_d && ((parcel_q.size() + inflight.size()) < DEPTH);
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic            req;
    logic [NV-1:0]   v;
    logic [PS-1:0]   d;
    logic [XLEN-1:0] p;
    logic            m, f;
    req = model_req();
    v = '0; d = '0; p = '0; m = 1'b0; f = 1'b0;
    if (!rst && parcel_q.size() > 0) begin
      v = '1;
      d = parcel_q[0].data;
      p = parcel_q[0].pc;
      m = (p % 4) != 0;
      f = parcel_q[0].err;
    end
    return {req, !(req && ack_d), pc_d & ~XLEN'(3), v, d, p, m, f};
  endfunction

  task automatic apply();
    if_stall   = stall_d;
    if_flush   = flush_d;
    mem_ack    = ack_d;
    if_nxt_pc  = pc_d;
    mem_rvalid = rv_en && (inflight.size() > 0) && (inflight[0].cyc < cyc);
    mem_d      = mem_rvalid ? inflight[0].data : PS'($urandom);
    mem_err    = mem_rvalid ? inflight[0].err : 1'($urandom_range(0, 1));
    #1;
  endtask

  task automatic advance();
    logic    pop, acc;
    req_t    e;
    parcel_t p;
    pop = (parcel_q.size() > 0) && !stall_d;
    acc = model_req() && ack_d;
    if (flush_d) begin
      if (mem_rvalid) e = inflight.pop_front();
      foreach (inflight[i]) inflight[i].live = 1'b0;
      parcel_q.delete();
    end else begin
      if (pop) p = parcel_q.pop_front();
      if (mem_rvalid) begin
        e = inflight.pop_front();
        if (e.live) begin
          p.pc = e.pc; p.data = e.data; p.err = e.err;
          parcel_q.push_back(p);
        end
      end
      if (acc) begin
        e.pc   = pc_d;
        e.data = PS'($urandom);
        e.err  = err_rand ? 1'($urandom_range(0, 1)) : (pc_d == err_pc);
        e.live = 1'b1;
        e.cyc  = cyc;
        inflight.push_back(e);
        pc_d = (pc_tab.size() > 0) ? pc_tab.pop_front() : pc_d + 4;
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    stall_d = 1'b0; flush_d = 1'b0; ack_d = 1'b0; rv_en = 1'b1;
    for (int i = 0; i < 20 && (parcel_q.size() + inflight.size()) > 0; i++) begin
      apply();
      advance();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall_d = 1'b0; flush_d = 1'b0; ack_d = 1'b1; rv_en = 1'b0; err_rand = 1'b0;
    err_pc = '1; pc_d = 32'h200;
    @(negedge clk);
    apply();
    n_vec++;
    if ({mem_req, if_stall_nxt_pc} !== 2'b01)
      begin n_err++; $display("FAIL reset_req got=%b required=01", {mem_req, if_stall_nxt_pc}); end
    n_vec++;
    if ({if_parcel_valid, if_parcel, if_parcel_pc, if_parcel_misaligned, if_parcel_page_fault} !== '0)
      begin n_err++; $display("FAIL reset_head got valid=%b parcel=%h pc=%h required all zero", if_parcel_valid, if_parcel, if_parcel_pc); end
    advance();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    stall_d = 1'b0; flush_d = 1'b0; ack_d = 1'b1; rv_en = 1'b1; pc_d = 32'h200;
    for (int i = 0; i < 12; i++) begin
      apply();
      n_vec++;
      if (act_vec !== exp_vec())
        begin n_err++; $display("FAIL stream cyc=%0d got=%h required=%h", cyc, act_vec, exp_vec()); end
      if (i < 3) begin
        n_vec++;
        if (mem_adr !== 32'h200 + 32'(4 * i) || mem_req !== 1'b1)
          begin n_err++; $display("FAIL stream_adr i=%0d got=%h required=%h", i, mem_adr, 32'h200 + 32'(4 * i)); end
      end
      if (i >= 2) begin
        n_vec++;
        if (if_parcel_valid !== 2'b11 || if_parcel_pc !== 32'h200 + 32'(4 * (i - 2)))
          begin n_err++; $display("FAIL stream_head i=%0d got valid=%b pc=%h required 11/%h", i, if_parcel_valid, if_parcel_pc, 32'h200 + 32'(4 * (i - 2))); end
      end
      advance();
    end
  endtask

  task automatic test_stall_full();
    int acc_cnt;
    drain();
    stall_d = 1'b1; ack_d = 1'b1; rv_en = 1'b1; pc_d = 32'h400; pc_tab.delete();
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      apply();
      n_vec++;
      if (act_vec !== exp_vec())
        begin n_err++; $display("FAIL stall_fill cyc=%0d got=%h required=%h", cyc, act_vec, exp_vec()); end
      if (mem_req && mem_ack) acc_cnt++;
      advance();
    end
    n_vec++;
    if (acc_cnt !== DEPTH)
      begin n_err++; $display("FAIL stall_accepts got=%0d required=%0d", acc_cnt, DEPTH); end
    apply();
    n_vec++;
    if (mem_req !== 1'b0 || if_stall_nxt_pc !== 1'b1)
      begin n_err++; $display("FAIL stall_full_req got req=%b stall_nxt=%b required 0/1", mem_req, if_stall_nxt_pc); end
    advance();
    stall_d = 1'b0;
    for (int i = 0; i < 8; i++) begin
      apply();
      n_vec++;
      if (act_vec !== exp_vec())
        begin n_err++; $display("FAIL stall_release cyc=%0d got=%h required=%h", cyc, act_vec, exp_vec()); end
      if (i < 4) begin
        n_vec++;
        if (if_parcel_valid !== 2'b11 || if_parcel_pc !== 32'h400 + 32'(4 * i))
          begin n_err++; $display("FAIL stall_pop i=%0d got pc=%h required=%h", i, if_parcel_pc, 32'h400 + 32'(4 * i)); end
      end
      advance();
    end
  endtask

  task automatic test_flush();
    logic seen;
    drain();
    stall_d = 1'b0; ack_d = 1'b1; rv_en = 1'b0; pc_d = 32'h600;
    for (int i = 0; i < 3; i++) begin
      apply();
      n_vec++;
      if (act_vec !== exp_vec())
        begin n_err++; $display("FAIL flush_issue cyc=%0d got=%h required=%h", cyc, act_vec, exp_vec()); end
      advance();
    end
    ack_d = 1'b0; flush_d = 1'b1;
    apply();
    n_vec++;
    if (act_vec !== exp_vec())
      begin n_err++; $display("FAIL flush_cycle got=%h required=%h", act_vec, exp_vec()); end
    advance();
    flush_d = 1'b0; pc_d = 32'h800; rv_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply();
      n_vec++;
      if (act_vec !== exp_vec() || if_parcel_valid !== '0)
        begin n_err++; $display("FAIL flush_drop i=%0d got=%h required=%h", i, act_vec, exp_vec()); end
      advance();
    end
    ack_d = 1'b1; seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      apply();
      n_vec++;
      if (act_vec !== exp_vec())
        begin n_err++; $display("FAIL flush_resume cyc=%0d got=%h required=%h", cyc, act_vec, exp_vec()); end
      if (i == 0) begin
        n_vec++;
        if (mem_req !== 1'b1 || mem_adr !== 32'h800)
          begin n_err++; $display("FAIL flush_first_req got req=%b adr=%h required 1/00000800", mem_req, mem_adr); end
      end
      if (!seen && if_parcel_valid != '0) begin
        seen = 1'b1;
        n_vec++;
        if (if_parcel_pc !== 32'h800)
          begin n_err++; $display("FAIL flush_first_pc got=%h required=00000800", if_parcel_pc); end
      end
      advance();
    end
    if (!seen) begin n_vec++; n_err++; $display("FAIL flush_first_pc timeout no parcel after flush"); end
  endtask

  task automatic test_flush_rvalid();
    logic seen;
    drain();
    ack_d = 1'b1; rv_en = 1'b0; pc_d = 32'h700;
    for (int i = 0; i < 2; i++) begin
      apply();
      n_vec++;
      if (act_vec !== exp_vec())
        begin n_err++; $display("FAIL flrv_issue cyc=%0d got=%h required=%h", cyc, act_vec, exp_vec()); end
      advance();
    end
    ack_d = 1'b0; flush_d = 1'b1; rv_en = 1'b1;
    apply();
    n_vec++;
    if (act_vec !== exp_vec())
      begin n_err++; $display("FAIL flrv_cycle got=%h required=%h", act_vec, exp_vec()); end
    advance();
    flush_d = 1'b0; pc_d = 32'h900;
    apply();
    n_vec++;
    if (act_vec !== exp_vec() || if_parcel_valid !== '0)
      begin n_err++; $display("FAIL flrv_second_drop got=%h required=%h", act_vec, exp_vec()); end
    advance();
    ack_d = 1'b1; seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      apply();
      n_vec++;
      if (act_vec !== exp_vec())
        begin n_err++; $display("FAIL flrv_resume cyc=%0d got=%h required=%h", cyc, act_vec, exp_vec()); end
      if (i == 0) begin
        n_vec++;
        if (mem_req !== 1'b1 || if_parcel_valid !== '0)
          begin n_err++; $display("FAIL flrv_discard_done got req=%b valid=%b required 1/00", mem_req, if_parcel_valid); end
      end
      if (!seen && if_parcel_valid != '0) begin
        seen = 1'b1;
        n_vec++;
        if (if_parcel_pc !== 32'h900)
          begin n_err++; $display("FAIL flrv_first_pc got=%h required=00000900", if_parcel_pc); end
      end
      advance();
    end
    if (!seen) begin n_vec++; n_err++; $display("FAIL flrv_first_pc timeout no parcel after flush"); end
  endtask

  task automatic test_misaligned_err();
    logic seen;
    drain();
    stall_d = 1'b1; ack_d = 1'b1; rv_en = 1'b1; err_rand = 1'b0; err_pc = 32'h204;
    pc_d = 32'h202; pc_tab.delete(); pc_tab.push_back(32'h204); pc_tab.push_back(32'h208);
    for (int i = 0; i < 6; i++) begin
      apply();
      n_vec++;
      if (act_vec !== exp_vec())
        begin n_err++; $display("FAIL mis_fill cyc=%0d got=%h required=%h", cyc, act_vec, exp_vec()); end
      if (i == 0) begin
        n_vec++;
        if (mem_adr !== 32'h200)
          begin n_err++; $display("FAIL mis_adr got=%h required=00000200", mem_adr); end
      end
      advance();
    end
    apply();
    n_vec++;
    if (if_parcel_pc !== 32'h202 || if_parcel_misaligned !== 1'b1 || if_parcel_page_fault !== 1'b0)
      begin n_err++; $display("FAIL mis_head got pc=%h mis=%b pf=%b required 00000202/1/0", if_parcel_pc, if_parcel_misaligned, if_parcel_page_fault); end
    advance();
    stall_d = 1'b0; seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      apply();
      n_vec++;
      if (act_vec !== exp_vec())
        begin n_err++; $display("FAIL mis_pop cyc=%0d got=%h required=%h", cyc, act_vec, exp_vec()); end
      if (if_parcel_valid != '0 && if_parcel_pc != 32'h202) begin
        if (if_parcel_pc == 32'h204) seen = 1'b1;
        n_vec++;
        if (if_parcel_page_fault !== (if_parcel_pc == 32'h204) || if_parcel_misaligned !== 1'b0)
          begin n_err++; $display("FAIL mis_flags pc=%h got mis=%b pf=%b required 0/%b", if_parcel_pc, if_parcel_misaligned, if_parcel_page_fault, if_parcel_pc == 32'h204); end
      end
      advance();
    end
    if (!seen) begin n_vec++; n_err++; $display("FAIL mis_err_entry timeout pc 00000204 never at head"); end
    err_pc = '1;
  endtask

  task automatic test_async_reset();
    logic reached, seen;
    drain();
    stall_d = 1'b1; ack_d = 1'b1; pc_d = 32'hA00; reached = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (parcel_q.size() == 2 && inflight.size() == 2) begin reached = 1'b1; break; end
      rv_en = parcel_q.size() < 2;
      apply();
      n_vec++;
      if (act_vec !== exp_vec())
        begin n_err++; $display("FAIL arst_setup cyc=%0d got=%h required=%h", cyc, act_vec, exp_vec()); end
      advance();
    end
    if (!reached) begin n_vec++; n_err++; $display("FAIL arst_setup timeout queued=%0d inflight=%0d", parcel_q.size(), inflight.size()); end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({mem_req, if_stall_nxt_pc, if_parcel_valid, if_parcel, if_parcel_pc, if_parcel_misaligned, if_parcel_page_fault} !== {1'b0, 1'b1, {(NV + PS + XLEN + 2){1'b0}}})
      begin n_err++; $display("FAIL arst_outputs got req=%b stall_nxt=%b valid=%b pc=%h required 0/1/00/00000000", mem_req, if_stall_nxt_pc, if_parcel_valid, if_parcel_pc); end
    inflight.delete(); parcel_q.delete(); pc_tab.delete();
    @(negedge clk);
    rv_en = 1'b0;
    apply();
    n_vec++;
    if (act_vec !== exp_vec())
      begin n_err++; $display("FAIL arst_hold got=%h required=%h", act_vec, exp_vec()); end
    advance();
    rst = 1'b0; stall_d = 1'b0; rv_en = 1'b1; pc_d = 32'h1000; seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      apply();
      n_vec++;
      if (act_vec !== exp_vec())
        begin n_err++; $display("FAIL arst_resume cyc=%0d got=%h required=%h", cyc, act_vec, exp_vec()); end
      if (i == 0) begin
        n_vec++;
        if (mem_req !== 1'b1 || mem_adr !== 32'h1000)
          begin n_err++; $display("FAIL arst_first_req got req=%b adr=%h required 1/00001000", mem_req, mem_adr); end
      end
      if (!seen && if_parcel_valid != '0) begin
        seen = 1'b1;
        n_vec++;
        if (if_parcel_pc !== 32'h1000)
          begin n_err++; $display("FAIL arst_first_pc got=%h required=00001000", if_parcel_pc); end
      end
      advance();
    end
    if (!seen) begin n_vec++; n_err++; $display("FAIL arst_first_pc timeout no parcel after reset"); end
  endtask

  task automatic test_random();
    logic was_flush;
    err_rand = 1'b1; was_flush = 1'b0; pc_tab.delete();
    for (int i = 0; i < 400; i++) begin
      if (was_flush) pc_d = XLEN'($urandom);
      stall_d = $urandom_range(0, 3) == 0;
      ack_d   = $urandom_range(0, 3) != 0;
      rv_en   = $urandom_range(0, 2) != 0;
      flush_d = $urandom_range(0, 24) == 0;
      apply();
      n_vec++;
      if (act_vec !== exp_vec())
        begin n_err++; $display("FAIL random cyc=%0d got=%h required=%h", cyc, act_vec, exp_vec()); end
      was_flush = flush_d;
      advance();
    end
    flush_d = 1'b0;
    err_rand = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    if_stall = 1'b0; if_flush = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0;
    mem_d = '0; mem_err = 1'b0; if_nxt_pc = '0;
    #1;
    test_reset();
    test_stream();
    test_stall_full();
    test_flush();
    test_flush_rvalid();
    test_misaligned_err();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
